// File: rtl/button_conditioner_if.sv
// Raw push-button levels in, conditioned single-cycle game-move pulses out.
// The DUT connects through the slave modport; the driver of the raw levels uses master.
interface button_conditioner_if;
    logic btn_right_raw;
    logic btn_left_raw;
    logic btn_drop_raw;
    logic move_right;
    logic move_left;
    logic drop_piece;

    modport master (
        output btn_right_raw, btn_left_raw, btn_drop_raw,
        input  move_right, move_left, drop_piece
    );

    modport slave (
        input  btn_right_raw, btn_left_raw, btn_drop_raw,
        output move_right, move_left, drop_piece
    );
endinterface

// File: rtl/button_conditioner.sv
// Three-channel push-button front end: 2-flop sync, debounce, press detect, registered pulse.
// Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat on the left/right channels.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 3750000
) (
    input  logic                clk_25MHz,
    input  logic                rst_n,
    button_conditioner_if.slave btn
);

    localparam int NUM_CH   = 3;
    localparam int CH_RIGHT = 0;
    localparam int CH_LEFT  = 1;
    localparam int CH_DROP  = 2;
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_PERIOD < 2) begin : g_bad_period
        $error("REPEAT_PERIOD must be at least 2");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("REPEAT_DELAY must be at least 1");
    end

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] stable_nxt;
    logic [NUM_CH-1:0] stable_d;
    logic [NUM_CH-1:0] press;
    logic [DB_W-1:0]   db_cnt     [NUM_CH];
    logic [DB_W-1:0]   db_cnt_nxt [NUM_CH];
    logic [1:0]        rpt_event;
    logic              ev_right;
    logic              ev_left;
    logic              move_right_q;
    logic              move_left_q;
    logic              drop_piece_q;

    assign raw = {btn.btn_drop_raw, btn.btn_left_raw, btn.btn_right_raw};

    // NOTE: every output gets a default before any branch so no path leaves a value held (no latch).
    always_comb begin
        stable_nxt = stable;
        db_cnt_nxt = '{default: '0};
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync2[i] != stable[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // NOTE: state uses <= so every flop samples pre-edge values; the counters are plain
    // registers, not memories, so they are all cleared in reset alongside the flops.
    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable   <= stable_nxt;
            stable_d <= stable;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
            end
        end
    end

    // Press is the debounced 0->1 transition; releases are deliberately silent.
    assign press = stable & ~stable_d;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt [2];
    logic [1:0]       rpt_armed;

    // Gating with stable_nxt suppresses a repeat on the very edge the release lands.
    always_comb begin
        rpt_event = '0;
        for (int i = 0; i < 2; i++) begin
            rpt_event[i] = rpt_armed[i] & stable_nxt[i] & (rpt_cnt[i] == '0);
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            rpt_armed <= '0;
            for (int i = 0; i < 2; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!stable_nxt[i]) begin
                    rpt_armed[i] <= 1'b0;
                    rpt_cnt[i]   <= '0;
                end else if (press[i]) begin
                    rpt_armed[i] <= 1'b1;
                    rpt_cnt[i]   <= RPT_FIRST;
                end else if (rpt_armed[i]) begin
                    if (rpt_cnt[i] == '0) begin
                        rpt_cnt[i] <= RPT_NEXT;
                    end else begin
                        rpt_cnt[i] <= rpt_cnt[i] - RPT_W'(1);
                    end
                end
            end
        end
    end
`else
    assign rpt_event = '0;
`endif

    // Simultaneous left and right events cancel each other; drop is independent.
    assign ev_right = press[CH_RIGHT] | rpt_event[CH_RIGHT];
    assign ev_left  = press[CH_LEFT]  | rpt_event[CH_LEFT];

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            move_right_q <= 1'b0;
            move_left_q  <= 1'b0;
            drop_piece_q <= 1'b0;
        end else begin
            move_right_q <= ev_right & ~ev_left;
            move_left_q  <= ev_left & ~ev_right;
            drop_piece_q <= press[CH_DROP];
        end
    end

    assign btn.move_right = move_right_q;
    assign btn.move_left  = move_left_q;
    assign btn.drop_piece = drop_piece_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: reset, clean press, bounce, left/right
// cancellation, reset mid-debounce and auto-repeat (or its absence).
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   edge_no = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   overlap = 0;
    int   q_right[$];
    int   q_left[$];
    int   q_drop[$];

    button_conditioner_if bif();

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk_25MHz(clk),
        .rst_n    (rst_n),
        .btn      (bif)
    );

    always #20 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Pulses are logged on the falling edge with the number of the edge that produced them.
    always @(negedge clk) begin
        if (bif.move_right) q_right.push_back(edge_no);
        if (bif.move_left)  q_left.push_back(edge_no);
        if (bif.drop_piece) q_drop.push_back(edge_no);
        if (bif.move_right && bif.move_left) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int e;
        int r;
        int p;
        int base_r;
        int base_l;
        int base_d;
        int got;
        int exp_rpt[$];

        // Reset with drop held: outputs stay low, then one fresh press after release.
        rst_n = 1'b0;
        bif.btn_right_raw = 1'b0;
        bif.btn_left_raw  = 1'b0;
        bif.btn_drop_raw  = 1'b1;
        tick(5);
        check("rst_move_right", int'(bif.move_right), 0);
        check("rst_move_left",  int'(bif.move_left),  0);
        check("rst_drop_piece", int'(bif.drop_piece), 0);
        base_d = q_drop.size();
        rst_n = 1'b1;
        e = edge_no + 1;
        tick(20);
        check("held_rst_count", q_drop.size() - base_d, 1);
        got = (q_drop.size() > base_d) ? q_drop[base_d] : -1;
        check("held_rst_edge", got, e + DB + 2);
        bif.btn_drop_raw = 1'b0;
        tick(15);

        // Clean press on drop, long hold, release: exactly one pulse.
        base_d = q_drop.size();
        bif.btn_drop_raw = 1'b1;
        e = edge_no + 1;
        tick(40);
        bif.btn_drop_raw = 1'b0;
        tick(20);
        check("clean_count", q_drop.size() - base_d, 1);
        got = (q_drop.size() > base_d) ? q_drop[base_d] : -1;
        check("clean_edge", got, e + DB + 2);

        // Bounce on right: 1,0,1,0 one cycle each, then a steady hold.
        base_r = q_right.size();
        base_l = q_left.size();
        bif.btn_right_raw = 1'b1; tick(1);
        bif.btn_right_raw = 1'b0; tick(1);
        bif.btn_right_raw = 1'b1; tick(1);
        bif.btn_right_raw = 1'b0; tick(1);
        bif.btn_right_raw = 1'b1;
        e = edge_no + 1;
        tick(15);
        bif.btn_right_raw = 1'b0;
        tick(25);
        check("bounce_count", q_right.size() - base_r, 1);
        got = (q_right.size() > base_r) ? q_right[base_r] : -1;
        check("bounce_edge", got, e + DB + 2);
        check("bounce_no_left", q_left.size() - base_l, 0);

        // Left and right together cancel; drop pressed alongside is unaffected.
        base_r = q_right.size();
        base_l = q_left.size();
        base_d = q_drop.size();
        bif.btn_left_raw  = 1'b1;
        bif.btn_right_raw = 1'b1;
        bif.btn_drop_raw  = 1'b1;
        e = edge_no + 1;
        tick(60);
        bif.btn_left_raw  = 1'b0;
        bif.btn_right_raw = 1'b0;
        bif.btn_drop_raw  = 1'b0;
        tick(25);
        check("sim_left_count",  q_left.size() - base_l, 0);
        check("sim_right_count", q_right.size() - base_r, 0);
        check("sim_drop_count",  q_drop.size() - base_d, 1);
        got = (q_drop.size() > base_d) ? q_drop[base_d] : -1;
        check("sim_drop_edge", got, e + DB + 2);

        // Reset on the 4th mismatched edge aborts the count; a fresh count follows.
        base_l = q_left.size();
        bif.btn_left_raw = 1'b1;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        r = edge_no + 1;
        tick(14);
        bif.btn_left_raw = 1'b0;
        tick(25);
        check("rstmid_count", q_left.size() - base_l, 1);
        got = (q_left.size() > base_l) ? q_left[base_l] : -1;
        check("rstmid_edge", got, r + DB + 2);

        // Long hold on right: repeats at P+20 then every 8 cycles, only with the macro.
        base_r = q_right.size();
        bif.btn_right_raw = 1'b1;
        e = edge_no + 1;
        p = e + DB + 2;
        tick(p + 53 - edge_no);
        bif.btn_right_raw = 1'b0;
        tick(40);
        exp_rpt.push_back(p);
`ifdef BUTTON_AUTOREPEAT_EN
        exp_rpt.push_back(p + 20);
        exp_rpt.push_back(p + 28);
        exp_rpt.push_back(p + 36);
        exp_rpt.push_back(p + 44);
        exp_rpt.push_back(p + 52);
`endif
        check("hold_count", q_right.size() - base_r, exp_rpt.size());
        foreach (exp_rpt[k]) begin
            got = (q_right.size() > base_r + k) ? q_right[base_r + k] : -1;
            check($sformatf("hold_edge_%0d", k), got, exp_rpt[k]);
        end

        check("left_right_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
